rx_sync_master_tx: RTL and testbench
====================================

RX_SYNC_MASTER_TX -- requirements
Module: rx_sync_master_tx

Interface
REQ-001 SHALL have parameter SYNC_ADDR, default 7'd72, serial register address decoded by this block.
REQ-002 SHALL have port master_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port serial_addr  input  7  settings bus address.
REQ-005 SHALL have port serial_data  input  32  settings bus data.
REQ-006 SHALL have port serial_strobe  input  1  settings bus write strobe, one cycle.
REQ-007 SHALL have port rx_sample_strobe  input  1  decimated-sample strobe used for alignment.
REQ-008 SHALL have port sync_out  output  1  registered sync pulse driven to the slave-sync pin.
REQ-009 SHALL have port sync_rx_local  output  1  registered one-cycle local RX sync pulse.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port overrun  output  1  sticky: fire received while busy.
REQ-012 SHALL have port fire_count  output  16  count of completed ARMED->ACTIVE transitions.

Function
REQ-013 SHALL treat a write as serial_strobe=1 and serial_addr=SYNC_ADDR; other addresses ignored.
REQ-014 SHALL decode write fields: [0] fire, [1] pin_en, [2] clr_overrun, [3] abort, [11:4] W (pulse width-1), [23:16] D (local delay); [31:24], [15:12] ignored.
REQ-015 SHALL latch pin_en, W, D only on a fire write accepted in IDLE; config held constant until return to IDLE.
REQ-016 SHALL implement states IDLE, ARMED, ACTIVE.
REQ-017 SHALL move IDLE->ARMED on the cycle after an accepted fire write (write in cycle n, busy=1 at n+1).
REQ-018 SHALL, in ARMED, wait for rx_sample_strobe=1; strobe high in cycle k (k>=n+1) -> ACTIVE from k+1.
REQ-019 SHALL drive sync_out=pin_en for exactly W+1 cycles, k+1 through k+1+W inclusive; 0 otherwise.
REQ-020 SHALL pulse sync_rx_local=1 for exactly one cycle at k+1+D (D=0 -> coincident with first sync_out cycle), regardless of pin_en.
REQ-021 SHALL return ACTIVE->IDLE on the cycle after max(k+1+W, k+1+D); busy low from that cycle.
REQ-022 SHALL increment fire_count by 1 on each ARMED->ACTIVE transition, wrapping 16'hFFFF->16'h0000.
REQ-023 SHALL ignore a fire write when busy=1 and set overrun=1 from next cycle; state, counters, config unaffected.
REQ-024 SHALL clear overrun on a write with clr_overrun=1; if same write also sets overrun (fire while busy), set wins.
REQ-025 SHALL, on a write with abort=1, enter IDLE next cycle with sync_out=0, sync_rx_local=0, fire_count unchanged; abort with fire in same write: abort wins, fire ignored, no overrun.
REQ-026 SHALL, with fire accepted in IDLE, ignore rx_sample_strobe in the write cycle itself.
REQ-027 SHALL use 8-bit width and delay counters; W=255 -> 256-cycle pulse, D=255 -> 255-cycle delay, no overflow.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, sync_out=0, sync_rx_local=0, busy=0, overrun=0, fire_count=0, latched config=0.
REQ-029 SHALL, on reset mid-ARMED/ACTIVE, drop all outputs next cycle with no further pulses; writes coincident with reset ignored.

Verification
REQ-030 SHALL cover: fire write (pin_en=1,W=3,D=0) cycle 10, rx_sample_strobe cycle 14 -> sync_out high 15..18, sync_rx_local high 15, busy 11..18, fire_count=1.
REQ-031 SHALL cover: W=0,D=5,pin_en=0 -> sync_out never high, sync_rx_local one cycle at k+6, busy drops at k+7.
REQ-032 SHALL cover: second fire during ACTIVE -> overrun=1, single pulse train only; clr_overrun write -> overrun=0 next cycle.
REQ-033 SHALL cover: abort write during ACTIVE (W=100) -> sync_out=0 and busy=0 next cycle, no sync_rx_local if not yet issued.
REQ-034 SHALL cover: preload 65535 fires -> next fire gives fire_count=0; reset mid-ACTIVE -> all outputs 0 next cycle.
REQ-035 SHALL cover: W=255,D=255 -> 256-cycle sync_out, sync_rx_local at k+256, IDLE at k+257.

Source files
------------

// File: rtl/rx_sync_master_tx.sv
// Purpose: settings-bus armed sync generator; aligns a slave-sync pulse and a local RX sync to the next decimated sample strobe.
// Latency: busy one cycle after an accepted fire write; pulses start the cycle after the aligning rx_sample_strobe.
// Backpressure: none; fire writes arriving while busy are dropped and flagged in the sticky overrun bit.
module rx_sync_master_tx #(
    parameter logic [6:0] SYNC_ADDR = 7'd72
) (
    input  logic        master_clk,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        rx_sample_strobe,
    output logic        sync_out,
    output logic        sync_rx_local,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] fire_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       start;

    // Decoded settings-bus write fields
    logic       wr;
    logic       wr_fire;
    logic       wr_clr;
    logic       wr_abort;
    logic       unused_data_bits;

    // Configuration captured on the accepted fire write
    logic       cfg_pin;
    logic [7:0] cfg_w;
    logic [7:0] cfg_d;

    // Cycles elapsed in ACTIVE (0 on the first ACTIVE cycle)
    logic [7:0] cnt;
    logic [7:0] span;

    assign wr               = serial_strobe && (serial_addr == SYNC_ADDR);
    assign wr_fire          = wr && serial_data[0];
    assign wr_clr           = wr && serial_data[2];
    assign wr_abort         = wr && serial_data[3];
    assign unused_data_bits = ^{serial_data[31:24], serial_data[15:12]};

    // ACTIVE lasts until both the pin pulse and the local delay have elapsed
    assign span = (cfg_w > cfg_d) ? cfg_w : cfg_d;
    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge master_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        if (wr_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_fire) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (rx_sample_strobe) begin
                        state_nxt = ACTIVE;
                        start     = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt == span) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Config capture, elapsed counter, fire counter and registered pulse outputs
    always_ff @(posedge master_clk) begin
        if (reset) begin
            cfg_pin       <= 1'b0;
            cfg_w         <= 8'd0;
            cfg_d         <= 8'd0;
            cnt           <= 8'd0;
            fire_count    <= 16'd0;
            sync_out      <= 1'b0;
            sync_rx_local <= 1'b0;
        end else begin
            if (state == IDLE && wr_fire && !wr_abort) begin
                cfg_pin <= serial_data[1];
                cfg_w   <= serial_data[11:4];
                cfg_d   <= serial_data[23:16];
            end

            if (start) begin
                cnt        <= 8'd0;
                fire_count <= fire_count + 16'd1;
            end else if (state == ACTIVE) begin
                cnt <= cnt + 8'd1;
            end

            if (state_nxt == ACTIVE) begin
                sync_out      <= cfg_pin && (start || (cnt < cfg_w));
                sync_rx_local <= start ? (cfg_d == 8'd0)
                                       : ((cfg_d != 8'd0) && (cnt == cfg_d - 8'd1));
            end else begin
                sync_out      <= 1'b0;
                sync_rx_local <= 1'b0;
            end
        end
    end

    // Sticky overrun: a dropped fire sets it, and setting beats a same-write clear
    always_ff @(posedge master_clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (wr_fire && busy && !wr_abort) begin
            overrun <= 1'b1;
        end else if (wr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_sync_master_tx.sv
// Purpose: self-checking bench for rx_sync_master_tx: vector table, directed corner sequences, random traffic vs a timestamp model.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_rx_sync_master_tx;

    localparam logic [6:0] SA = 7'd72;

    logic        master_clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  serial_addr = 7'd0;
    logic [31:0] serial_data = 32'd0;
    logic        serial_strobe = 1'b0;
    logic        rx_sample_strobe = 1'b0;
    logic        sync_out;
    logic        sync_rx_local;
    logic        busy;
    logic        overrun;
    logic [15:0] fire_count;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // Reference model: pulse train described by its start cycle and configured lengths
    bit m_valid = 1'b0;
    bit m_armed, m_active, m_pin, m_ov;
    int m_w, m_d, m_t0, m_count;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] dat;
        logic        rxs;
        logic        chk;
        logic        e_sync;
        logic        e_loc;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[22];

    rx_sync_master_tx #(.SYNC_ADDR(SA)) dut (
        .master_clk       (master_clk),
        .reset            (reset),
        .serial_addr      (serial_addr),
        .serial_data      (serial_data),
        .serial_strobe    (serial_strobe),
        .rx_sample_strobe (rx_sample_strobe),
        .sync_out         (sync_out),
        .sync_rx_local    (sync_rx_local),
        .busy             (busy),
        .overrun          (overrun),
        .fire_count       (fire_count)
    );

    always #5 master_clk = ~master_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit fire, input bit pin, input bit clr,
                                       input bit abort, input int w, input int d);
        logic [31:0] v;
        v        = $urandom;
        v[0]     = fire;
        v[1]     = pin;
        v[2]     = clr;
        v[3]     = abort;
        v[11:4]  = w[7:0];
        v[23:16] = d[7:0];
        return v;
    endfunction

    task automatic check_model();
        int   rel;
        logic es, el, eb;
        if (!m_valid) return;
        rel = t - m_t0;
        es  = m_active && m_pin && rel >= 0 && rel <= m_w;
        el  = m_active && rel == m_d;
        eb  = m_armed || m_active;
        check("m_sync_out", sync_out, es);
        check("m_sync_rx_local", sync_rx_local, el);
        check("m_busy", busy, eb);
        check("m_overrun", overrun, m_ov);
        check("m_fire_count", fire_count, m_count[15:0]);
    endtask

    // Advance the model by the inputs present in cycle t
    task automatic model_update();
        bit wr, fire, clr, abort, busy_now;
        int span;
        if (reset) begin
            m_valid  = 1'b1;
            m_armed  = 1'b0;
            m_active = 1'b0;
            m_pin    = 1'b0;
            m_ov     = 1'b0;
            m_w      = 0;
            m_d      = 0;
            m_t0     = 0;
            m_count  = 0;
            return;
        end
        wr       = serial_strobe && serial_addr == SA;
        fire     = wr && serial_data[0];
        clr      = wr && serial_data[2];
        abort    = wr && serial_data[3];
        busy_now = m_armed || m_active;
        span     = (m_w > m_d) ? m_w : m_d;
        if (abort) begin
            m_armed  = 1'b0;
            m_active = 1'b0;
        end else begin
            if (m_active && t == m_t0 + span) m_active = 1'b0;
            if (m_armed && rx_sample_strobe) begin
                m_armed  = 1'b0;
                m_active = 1'b1;
                m_t0     = t + 1;
                m_count  = (m_count + 1) % 65536;
            end
            if (fire && !busy_now) begin
                m_armed = 1'b1;
                m_pin   = serial_data[1];
                m_w     = int'(serial_data[11:4]);
                m_d     = int'(serial_data[23:16]);
            end
        end
        if (fire && busy_now && !abort) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
    endtask

    task automatic drive(input logic rst, input logic wr, input logic [6:0] a,
                         input logic [31:0] d, input logic rxs);
        reset            = rst;
        serial_strobe    = wr;
        serial_addr      = a;
        serial_data      = d;
        rx_sample_strobe = rxs;
        @(negedge master_clk);
        check_model();
    endtask

    task automatic advance();
        model_update();
        @(posedge master_clk);
        #1;
        t++;
    endtask

    task automatic step(input logic rst, input logic wr, input logic [6:0] a,
                        input logic [31:0] d, input logic rxs);
        drive(rst, wr, a, d, rxs);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, SA, 32'd0, 1'b0);
    endtask

    task automatic wr_cmd(input logic [31:0] d);
        step(1'b0, 1'b1, SA, d, 1'b0);
    endtask

    task automatic strobe();
        step(1'b0, 1'b0, SA, 32'd0, 1'b1);
    endtask

    initial begin
        int k, nsync, locat, idleat, nloc;

        // Fire (pin_en=1, W=3, D=0) in cycle 10, aligning strobe in cycle 14.
        // Stray strobes in 5 (IDLE), 10 (write cycle) and 16 (ACTIVE) must be ignored,
        // as must a fire to another address in cycle 7.
        for (int i = 0; i < 22; i++) begin
            tbl[i].rst    = (i < 2);
            tbl[i].wr     = (i == 10) || (i == 7);
            tbl[i].addr   = (i == 7) ? 7'd73 : SA;
            tbl[i].dat    = (i == 10 || i == 7) ? 32'h0000_0033 : 32'd0;
            tbl[i].rxs    = (i == 5) || (i == 10) || (i == 14) || (i == 16);
            tbl[i].chk    = (i >= 1);
            tbl[i].e_sync = (i >= 15 && i <= 18);
            tbl[i].e_loc  = (i == 15);
            tbl[i].e_busy = (i >= 11 && i <= 18);
            tbl[i].e_cnt  = (i >= 15) ? 16'd1 : 16'd0;
        end
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].addr, tbl[i].dat, tbl[i].rxs);
            if (tbl[i].chk) begin
                check("tbl_sync_out", sync_out, tbl[i].e_sync);
                check("tbl_sync_rx_local", sync_rx_local, tbl[i].e_loc);
                check("tbl_busy", busy, tbl[i].e_busy);
                check("tbl_fire_count", fire_count, tbl[i].e_cnt);
                check("tbl_overrun", overrun, 1'b0);
            end
            advance();
        end

        // W=0, D=5, pin_en=0: no pin pulse, local at k+6, busy drops at k+7
        wr_cmd(mk(1, 0, 0, 0, 0, 5));
        idle(2);
        k = t;
        strobe();
        nsync = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
            if (sync_out) nsync++;
            if (t == k + 6) check("d5_local_at_k6", sync_rx_local, 1'b1);
            if (t == k + 6) check("d5_busy_at_k6", busy, 1'b1);
            if (t == k + 7) check("d5_busy_drop_k7", busy, 1'b0);
            advance();
        end
        check("d5_no_pin_pulse", nsync, 0);

        // Second fire during ACTIVE: overrun, single train; then clear
        wr_cmd(mk(1, 1, 0, 0, 4, 0));
        strobe();
        idle(1);
        wr_cmd(mk(1, 1, 0, 0, 4, 0));
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("ovr_set", overrun, 1'b1);
        advance();
        idle(8);
        check("ovr_one_train", fire_count, 16'd3);
        wr_cmd(mk(0, 0, 1, 0, 0, 0));
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("ovr_cleared", overrun, 1'b0);
        advance();

        // Fire with clr while ARMED: set wins; then abort with fire: no overrun change, IDLE
        wr_cmd(mk(1, 1, 0, 0, 2, 2));
        wr_cmd(mk(1, 1, 1, 0, 2, 2));
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("ovr_set_wins", overrun, 1'b1);
        advance();
        wr_cmd(mk(1, 1, 1, 1, 2, 2));
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("abort_fire_idle", busy, 1'b0);
        check("abort_fire_no_ovr", overrun, 1'b0);
        advance();

        // Abort during a long ACTIVE before the local pulse is due
        wr_cmd(mk(1, 1, 0, 0, 100, 50));
        strobe();
        idle(5);
        wr_cmd(mk(0, 0, 0, 1, 0, 0));
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("abort_sync_low", sync_out, 1'b0);
        check("abort_busy_low", busy, 1'b0);
        advance();
        nloc = 0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
            if (sync_rx_local || sync_out) nloc++;
            advance();
        end
        check("abort_no_later_pulse", nloc, 0);

        // Fire counter wrap from 65535
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        force dut.fire_count = 16'hFFFF;
        #1;
        release dut.fire_count;
        m_count = 65535;
        advance();
        wr_cmd(mk(1, 1, 0, 0, 1, 0));
        strobe();
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("wrap_to_zero", fire_count, 16'h0000);
        advance();
        idle(3);

        // Reset mid-ACTIVE, with a fire write coincident with reset
        wr_cmd(mk(1, 1, 0, 0, 20, 10));
        strobe();
        idle(2);
        step(1'b1, 1'b1, SA, mk(1, 1, 0, 0, 5, 5), 1'b1);
        drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
        check("rst_sync", sync_out, 1'b0);
        check("rst_local", sync_rx_local, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fire_count, 16'd0);
        advance();
        idle(25);

        // Maximum width and delay
        wr_cmd(mk(1, 1, 0, 0, 255, 255));
        idle(1);
        k = t;
        strobe();
        nsync  = 0;
        locat  = -1;
        idleat = -1;
        for (int i = 0; i < 270; i++) begin
            drive(1'b0, 1'b0, SA, 32'd0, 1'b0);
            if (sync_out) nsync++;
            if (sync_rx_local) locat = t;
            if (!busy && idleat < 0) idleat = t;
            advance();
        end
        check("max_pulse_len", nsync, 256);
        check("max_local_at", locat, k + 256);
        check("max_idle_at", idleat, k + 257);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic        r_wr, r_rst, r_rxs;
            logic [6:0]  r_a;
            logic [31:0] r_d;
            r_rst = ($urandom_range(0, 599) == 0);
            r_wr  = ($urandom_range(0, 9) == 0);
            r_a   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : SA;
            r_d   = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 12), $urandom_range(0, 12));
            r_rxs = ($urandom_range(0, 3) == 0);
            step(r_rst, r_wr, r_a, r_d, r_rxs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
